// File: rtl/mem_arbiter.sv
// Two-requester Wishbone classic arbiter: instruction fetch and data ports share one master port.
// Round-robin on ties, ownership held for the whole cycle, and a stalled strobe times out into a one-cycle error.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ins_cyc_i,
  input  logic          ins_stb_i,
  input  logic [AW-1:0] ins_adr_i,
  output logic          ins_ack_o,
  output logic          ins_err_o,
  output logic [31:0]   ins_dat_o,
  input  logic          dat_cyc_i,
  input  logic          dat_stb_i,
  input  logic          dat_we_i,
  input  logic [3:0]    dat_sel_i,
  input  logic [AW-1:0] dat_adr_i,
  input  logic [31:0]   dat_dat_i,
  output logic          dat_ack_o,
  output logic          dat_err_o,
  output logic [31:0]   dat_dat_o,
  output logic          bus_cyc_o,
  output logic          bus_stb_o,
  output logic          bus_we_o,
  output logic [3:0]    bus_sel_o,
  output logic [AW-1:0] bus_adr_o,
  output logic [31:0]   bus_dat_o,
  input  logic          bus_ack_i,
  input  logic [31:0]   bus_dat_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INS  = 2'd1,
    DAT  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       last_dat, last_dat_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_dat <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      last_dat <= last_dat_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign grant_o   = state;
  assign ins_dat_o = bus_dat_i;
  assign dat_dat_o = bus_dat_i;

  always_comb begin
    state_nxt    = state;
    last_dat_nxt = last_dat;
    wait_cnt_nxt = 8'd0;
    bus_cyc_o    = 1'b0;
    bus_stb_o    = 1'b0;
    bus_we_o     = 1'b0;
    bus_sel_o    = 4'h0;
    bus_adr_o    = '0;
    bus_dat_o    = 32'h0;
    ins_ack_o    = 1'b0;
    ins_err_o    = 1'b0;
    dat_ack_o    = 1'b0;
    dat_err_o    = 1'b0;
    stall        = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the requester not granted last wins
        if (dat_cyc_i && (!ins_cyc_i || !last_dat)) begin
          state_nxt    = DAT;
          last_dat_nxt = 1'b1;
        end else if (ins_cyc_i) begin
          state_nxt    = INS;
          last_dat_nxt = 1'b0;
        end
      end
      INS: begin
        bus_cyc_o = ins_cyc_i;
        bus_stb_o = ins_stb_i;
        bus_adr_o = ins_adr_i;
        bus_sel_o = 4'hF;
        ins_ack_o = bus_ack_i;
        if (!ins_cyc_i) state_nxt = IDLE;
      end
      DAT: begin
        bus_cyc_o = dat_cyc_i;
        bus_stb_o = dat_stb_i;
        bus_we_o  = dat_we_i;
        bus_sel_o = dat_sel_i;
        bus_adr_o = dat_adr_i;
        bus_dat_o = dat_dat_i;
        dat_ack_o = bus_ack_i;
        if (!dat_cyc_i) state_nxt = IDLE;
      end
      default: begin
        // last_dat still names the owner that timed out
        ins_err_o = !last_dat;
        dat_err_o = last_dat;
        state_nxt = IDLE;
      end
    endcase

    // Timeout outranks a dropped cyc; a same-cycle ack clears the stall
    stall = bus_stb_o && !bus_ack_i;
    if (stall) begin
      wait_cnt_nxt = wait_cnt + 8'd1;
      if (wait_cnt == TIMEOUT - 8'd1) state_nxt = ERR;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed arbitration/timeout/reset scenarios plus randomized traffic,
// responses checked by a queue-based scoreboard fed from a transaction-level model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_cyc = 1'b0, ins_stb = 1'b0;
  logic [31:0] ins_adr = 32'h0;
  logic        ins_ack_o, ins_err_o;
  logic [31:0] ins_dat_o;
  logic        dat_cyc = 1'b0, dat_stb = 1'b0, dat_we = 1'b0;
  logic [3:0]  dat_sel = 4'h0;
  logic [31:0] dat_adr = 32'h0, dat_wdat = 32'h0;
  logic        dat_ack_o, dat_err_o;
  logic [31:0] dat_dat_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o, bus_dat_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_dat_i = 32'h0;
  logic [1:0]  grant_o;

  int   checks = 0;
  int   errors = 0;
  exp_t q_ins[$];
  exp_t q_dat[$];
  exp_t me;
  int   s_cnt = 0;
  int   gseq[30];

  mem_arbiter #(.AW(32), .TIMEOUT(8'(TMO))) dut (
    .clk_i(clk), .rst_i(rst),
    .ins_cyc_i(ins_cyc), .ins_stb_i(ins_stb), .ins_adr_i(ins_adr),
    .ins_ack_o(ins_ack_o), .ins_err_o(ins_err_o), .ins_dat_o(ins_dat_o),
    .dat_cyc_i(dat_cyc), .dat_stb_i(dat_stb), .dat_we_i(dat_we),
    .dat_sel_i(dat_sel), .dat_adr_i(dat_adr), .dat_dat_i(dat_wdat),
    .dat_ack_o(dat_ack_o), .dat_err_o(dat_err_o), .dat_dat_o(dat_dat_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_ack_i(bus_ack_i), .bus_dat_i(bus_dat_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Slave wait states are a property of the address so the model can predict them
  function automatic int lat(input logic [31:0] a);
    return int'(a[6:4] ^ 3'd2);
  endfunction

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endfunction

  // Slave: acks after lat(adr) stalled cycles; echoes the request fields into the read data
  always @(posedge clk) begin
    #2;
    if (bus_cyc_o && bus_stb_o) begin
      if (s_cnt == lat(bus_adr_o)) begin
        bus_ack_i = 1'b1;
        bus_dat_i = fdat(bus_adr_o) ^ bus_dat_o ^ {28'h0, bus_sel_o} ^ {bus_we_o, 31'h0};
        s_cnt = 0;
      end else begin
        bus_ack_i = 1'b0;
        bus_dat_i = $urandom;
        s_cnt++;
      end
    end else begin
      s_cnt = 0;
      bus_dat_i = $urandom;
      bus_ack_i = (grant_o == 2'd0 || grant_o == 2'd3) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever a requester sees ack or err
  always @(negedge clk) begin
    if (ins_ack_o || ins_err_o) begin
      checks++;
      if (q_ins.size() == 0) begin
        errors++;
        $display("FAIL ins_resp unexpected ack=%0b err=%0b required none", ins_ack_o, ins_err_o);
      end else begin
        me = q_ins.pop_front();
        if (ins_err_o !== me.err || ins_ack_o === ins_err_o || (!me.err && ins_dat_o !== me.data)) begin
          errors++;
          $display("FAIL ins_resp got err=%0b ack=%0b dat=%h required err=%0b dat=%h",
                   ins_err_o, ins_ack_o, ins_dat_o, me.err, me.data);
        end
      end
    end
    if (dat_ack_o || dat_err_o) begin
      checks++;
      if (q_dat.size() == 0) begin
        errors++;
        $display("FAIL dat_resp unexpected ack=%0b err=%0b required none", dat_ack_o, dat_err_o);
      end else begin
        me = q_dat.pop_front();
        if (dat_err_o !== me.err || dat_ack_o === dat_err_o || (!me.err && dat_dat_o !== me.data)) begin
          errors++;
          $display("FAIL dat_resp got err=%0b ack=%0b dat=%h required err=%0b dat=%h",
                   dat_err_o, dat_ack_o, dat_dat_o, me.err, me.data);
        end
      end
    end
    if (grant_o == 2'd0 || grant_o == 2'd3) begin
      checks++;
      if (bus_cyc_o || bus_stb_o) begin
        errors++;
        $display("FAIL idle_bus grant=%0d cyc=%0b stb=%0b required 0", grant_o, bus_cyc_o, bus_stb_o);
      end
    end
  end

  task automatic ins_txn(input logic [31:0] adr, input int beats);
    exp_t e;
    bit   done;
    int   n;
    @(posedge clk); #1;
    ins_cyc = 1'b1;
    ins_stb = 1'b1;
    for (int b = 0; b < beats; b++) begin
      ins_adr = adr + 32'(4 * b);
      e.err  = (lat(ins_adr) >= TMO);
      e.data = fdat(ins_adr) ^ 32'hF;
      q_ins.push_back(e);
      done = 1'b0;
      n = 0;
      while (!done && n < 400) begin
        @(negedge clk);
        n++;
        if (ins_ack_o || ins_err_o) done = 1'b1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL ins_wait no response for adr %h", ins_adr);
      end
      @(posedge clk); #1;
      if (e.err || !done) break;
    end
    ins_cyc = 1'b0;
    ins_stb = 1'b0;
  endtask

  task automatic dat_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd);
    exp_t e;
    bit   done;
    int   n;
    @(posedge clk); #1;
    dat_cyc  = 1'b1;
    dat_stb  = 1'b1;
    dat_adr  = adr;
    dat_we   = we;
    dat_sel  = sel;
    dat_wdat = wd;
    e.err  = (lat(adr) >= TMO);
    e.data = fdat(adr) ^ wd ^ {28'h0, sel} ^ {we, 31'h0};
    q_dat.push_back(e);
    done = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (dat_ack_o || dat_err_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL dat_wait no response for adr %h", adr);
    end
    @(posedge clk); #1;
    dat_cyc = 1'b0;
    dat_stb = 1'b0;
    dat_we  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int first1, last1, first2, gaps;
    logic [31:0] a;
    int w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o}, 32'h0);
    chk("rst_adr", bus_adr_o, 32'h0);
    chk("rst_dat", bus_dat_o, 32'h0);
    chk("rst_resp", {ins_ack_o, ins_err_o, dat_ack_o, dat_err_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch, two wait cycles
    fork
      ins_txn(32'h100, 1);
      begin
        @(posedge clk);
        @(negedge clk); chk("fetch_pre", 32'(grant_o), 32'd0);
        @(negedge clk); chk("fetch_grant", 32'(grant_o), 32'd1);
        chk("fetch_adr", bus_adr_o, 32'h100);
        chk("fetch_sel", 32'(bus_sel_o), 32'hF);
        @(negedge clk); chk("fetch_wait", 32'(ins_ack_o), 32'd0);
        @(negedge clk); chk("fetch_ack", 32'(ins_ack_o), 32'd1);
        chk("fetch_dat_ack", 32'(dat_ack_o), 32'd0);
      end
    join

    // Tie from reset history: DAT first, then INS via one IDLE cycle
    fork
      ins_txn(32'h120, 1);
      dat_txn(32'h4000_0030, 1'b1, 4'h3, 32'hDEAD_BEEF);
      begin
        @(posedge clk);
        @(negedge clk); chk("tie_pre", 32'(grant_o), 32'd0);
        @(negedge clk); chk("tie_dat", 32'(grant_o), 32'd2);
        cnt = 0;
        while (!dat_ack_o && cnt < 50) begin @(negedge clk); cnt++; end
        chk("tie_dat_ack", 32'(dat_ack_o), 32'd1);
        @(negedge clk); chk("tie_hold", {30'h0, grant_o}, 32'd2);
        chk("tie_drop_cyc", 32'(bus_cyc_o), 32'd0);
        @(negedge clk); chk("tie_gap", 32'(grant_o), 32'd0);
        @(negedge clk); chk("tie_ins", 32'(grant_o), 32'd1);
      end
    join

    fork
      ins_txn(32'h140, 1);
      dat_txn(32'h150, 1'b0, 4'hF, 32'h0);
      begin
        @(posedge clk);
        @(negedge clk);
        @(negedge clk); chk("tie2_dat", 32'(grant_o), 32'd2);
      end
    join

    // Two-beat fetch with data requesting one cycle later
    fork
      ins_txn(32'h200, 2);
      begin @(posedge clk); dat_txn(32'h310, 1'b0, 4'hF, 32'h0); end
      begin
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin @(negedge clk); gseq[i] = int'(grant_o); end
      end
    join
    first1 = -1; last1 = -1; first2 = -1; gaps = 0;
    for (int i = 0; i < 30; i++) begin
      if (gseq[i] == 1 && first1 < 0) first1 = i;
      if (gseq[i] == 1) last1 = i;
      if (gseq[i] == 2 && first2 < 0) first2 = i;
    end
    for (int i = 0; i < 30; i++)
      if (first1 >= 0 && i > first1 && i < last1 && gseq[i] != 1) gaps++;
    chk("twobeat_hold", 32'(gaps), 32'd0);
    chk("twobeat_handoff", 32'(first2), 32'(last1 + 2));

    // Timeout on a write: ERR after four stalled cycles
    fork
      dat_txn(32'h1060, 1'b1, 4'h5, 32'h1234_5678);
      begin
        @(posedge clk);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (grant_o != 2'd2 && cnt < 10);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!dat_err_o && cnt < 10);
        chk("tmo_cycles", 32'(cnt), 32'd4);
        chk("tmo_cyc_low", 32'(bus_cyc_o), 32'd0);
        chk("tmo_grant", 32'(grant_o), 32'd3);
        chk("tmo_ins_err", 32'(ins_err_o), 32'd0);
        @(negedge clk); chk("tmo_after", {30'h0, grant_o}, 32'd0);
        chk("tmo_err_once", 32'(dat_err_o), 32'd0);
      end
    join

    // Ack on the fourth stalled cycle wins over the timeout
    fork
      dat_txn(32'h2010, 1'b0, 4'hF, 32'h0);
      begin
        @(posedge clk);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (grant_o != 2'd2 && cnt < 10);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!dat_ack_o && !dat_err_o && cnt < 10);
        chk("edge_cycles", 32'(cnt), 32'd3);
        chk("edge_ack", {dat_ack_o, dat_err_o}, 32'd2);
        chk("edge_grant", 32'(grant_o), 32'd2);
      end
    join

    // Reset mid-transfer aborts silently
    @(posedge clk); #1;
    dat_cyc = 1'b1; dat_stb = 1'b1; dat_we = 1'b1; dat_sel = 4'hF; dat_adr = 32'h70;
    @(posedge clk); #1;
    @(negedge clk); chk("rstmid_pre", 32'(grant_o), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_cyc", 32'(bus_cyc_o), 32'd0);
    chk("rstmid_grant", 32'(grant_o), 32'd0);
    chk("rstmid_resp", {ins_ack_o, ins_err_o, dat_ack_o, dat_err_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dat_cyc = 1'b0; dat_stb = 1'b0; dat_we = 1'b0;

    // Randomized concurrent traffic
    fork
      for (int t = 0; t < 25; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        a = $urandom;
        a[1:0] = 2'b00;
        w = $urandom_range(0, 5);
        a[6:4] = 3'(w) ^ 3'd2;
        ins_txn(a, $urandom_range(1, 2));
      end
      for (int t = 0; t < 25; t++) begin
        logic [31:0] da;
        int dw;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        da = $urandom;
        da[1:0] = 2'b00;
        dw = $urandom_range(0, 5);
        da[6:4] = 3'(dw) ^ 3'd2;
        dat_txn(da, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      end
    join

    repeat (5) @(posedge clk);
    chk("ins_queue_empty", 32'(q_ins.size()), 32'd0);
    chk("dat_queue_empty", 32'(q_dat.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
